// File: rtl/fpga_cmd_pkg.sv
// fpga_cmd_pkg
// Shared definitions for the SPI command receiver and its consumers:
//   - command opcodes carried in the top nibble of a command word
//   - major-mode encodings for conf_word[7:5]
//   - the readback tag that leads every miso status word
//   - reset values of the configuration registers
//   - the receiver FSM state type
package fpga_cmd_pkg;

    // Command opcodes
    localparam logic [3:0] FPGA_CMD_SET_CONFREG = 4'b0001;
    localparam logic [3:0] FPGA_CMD_SET_DIVISOR = 4'b0010;
    localparam logic [3:0] FPGA_CMD_CLR_STATUS  = 4'b0011;

    // Major modes; MODE_7 is the "everything off" mode selected after reset
    localparam logic [2:0] FPGA_MAJOR_MODE_0 = 3'b000;
    localparam logic [2:0] FPGA_MAJOR_MODE_1 = 3'b001;
    localparam logic [2:0] FPGA_MAJOR_MODE_2 = 3'b010;
    localparam logic [2:0] FPGA_MAJOR_MODE_3 = 3'b011;
    localparam logic [2:0] FPGA_MAJOR_MODE_4 = 3'b100;
    localparam logic [2:0] FPGA_MAJOR_MODE_5 = 3'b101;
    localparam logic [2:0] FPGA_MAJOR_MODE_6 = 3'b110;
    localparam logic [2:0] FPGA_MAJOR_MODE_7 = 3'b111;

    // Leading nibble of the readback word, lets the ARM recognise a live FPGA
    localparam logic [3:0] FPGA_READBACK_TAG = 4'b1010;

    // Register reset values
    localparam logic [7:0] CONF_WORD_RESET = {FPGA_MAJOR_MODE_7, 5'b00000};
    localparam logic [7:0] DIVISOR_RESET   = 8'd95;

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DECODE = 2'd2
    } rxState_e;

endpackage

// File: rtl/fpga_spi_cmd_rx_sync_edge.sv
// sync_edge
// Multi-stage synchroniser for one asynchronous input, followed by a history
// flop so that rising and falling edges of the synchronised level can be
// reported as single-cycle pulses.
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-high reset
//   din_i    asynchronous input pin
//   level_o  synchronised level (STAGES cycles behind the pin)
//   rise_o   one-cycle pulse on a synchronised 0->1 transition
//   fall_o   one-cycle pulse on a synchronised 1->0 transition
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Synchroniser chain plus history flop. Everything resets to the idle
    // level of the pin so no spurious edge appears right after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/fpga_spi_cmd_rx.sv
// fpga_spi_cmd_rx
// Single-clock SPI command receiver. The ARM's spck/mosi/ncs pins are
// synchronised into the pck0 domain, command words are assembled on spck
// rising edges, and on ncs rising the word is decoded into the configuration
// registers that drive the HF mode mux. A status word is shifted out on miso,
// advancing on spck falling edges.
// Ports:
//   pck0        system clock
//   rst         asynchronous active-high reset
//   spck        SPI clock from the ARM (asynchronous)
//   mosi        SPI data from the ARM, sampled on spck rising
//   ncs         SPI chip select, active low
//   miso        readback data, MSB first
//   conf_word   configuration register (major mode [7:5], options [2:0])
//   divisor     LF/aux divisor register
//   cmd_valid   one-cycle pulse per accepted command
//   cmd_opcode  opcode of the last accepted command
//   frame_err   sticky malformed-frame flag, cleared by CLR_STATUS
module fpga_spi_cmd_rx
    import fpga_cmd_pkg::*;
#(
    parameter int CMD_BITS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       pck0,
    input  logic       rst,
    input  logic       spck,
    input  logic       mosi,
    input  logic       ncs,
    output logic       miso,
    output logic [7:0] conf_word,
    output logic [7:0] divisor,
    output logic       cmd_valid,
    output logic [3:0] cmd_opcode,
    output logic       frame_err
);

    // The bit counter must be able to hold CMD_BITS + 1 so that an over-long
    // frame is distinguishable from a correct one.
    localparam int               CNT_W   = $clog2(CMD_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_OK  = CNT_W'(CMD_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CMD_BITS + 1);

    logic spckRise, spckFall, spckLevelUnused;
    logic mosiLevel, mosiRiseUnused, mosiFallUnused;
    logic ncsRise, ncsFall, ncsLevelUnused;

    rxState_e            state_q;
    logic [CMD_BITS-1:0] shiftReg_q;
    logic [CMD_BITS-1:0] txReg_q;
    logic [CNT_W-1:0]    bitCnt_q;
    logic                miso_q;
    logic [7:0]          confWord_q;
    logic [7:0]          divisor_q;
    logic                cmdValid_q;
    logic [3:0]          cmdOpcode_q;
    logic                frameErr_q;

    logic [CMD_BITS-1:0] shiftIn_d;
    logic [CMD_BITS-1:0] txShift_d;
    logic [CMD_BITS-1:0] txLoad_d;
    logic [3:0]          opcodeField;
    logic [CMD_BITS-13:0] reservedUnused;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSpckSync (
        .clk_i   (pck0),
        .rst_i   (rst),
        .din_i   (spck),
        .level_o (spckLevelUnused),
        .rise_o  (spckRise),
        .fall_o  (spckFall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uMosiSync (
        .clk_i   (pck0),
        .rst_i   (rst),
        .din_i   (mosi),
        .level_o (mosiLevel),
        .rise_o  (mosiRiseUnused),
        .fall_o  (mosiFallUnused)
    );

    // ncs idles high, so its synchroniser resets high to avoid a false
    // frame start after reset release.
    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uNcsSync (
        .clk_i   (pck0),
        .rst_i   (rst),
        .din_i   (ncs),
        .level_o (ncsLevelUnused),
        .rise_o  (ncsRise),
        .fall_o  (ncsFall)
    );

    // Next values of the data shifters and the readback word loaded at the
    // start of each frame: tag, zero pad, sticky error, current conf_word.
    assign shiftIn_d      = {shiftReg_q[CMD_BITS-2:0], mosiLevel};
    assign txShift_d      = {txReg_q[CMD_BITS-2:0], 1'b0};
    assign txLoad_d       = {FPGA_READBACK_TAG, {(CMD_BITS-13){1'b0}}, frameErr_q, confWord_q};
    assign opcodeField    = shiftReg_q[CMD_BITS-1 -: 4];
    assign reservedUnused = shiftReg_q[CMD_BITS-5:8];

    // Receiver FSM. All outputs are registered here so the configuration
    // registers only ever move on the single DECODE cycle, and miso is
    // forced low whenever no frame is in progress. spck edges are only acted
    // on in SHIFT, which is how edges with ncs high get ignored.
    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shiftReg_q  <= '0;
            txReg_q     <= '0;
            bitCnt_q    <= '0;
            miso_q      <= 1'b0;
            confWord_q  <= CONF_WORD_RESET;
            divisor_q   <= DIVISOR_RESET;
            cmdValid_q  <= 1'b0;
            cmdOpcode_q <= 4'd0;
            frameErr_q  <= 1'b0;
        end else begin
            cmdValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (ncsFall) begin
                        state_q  <= SHIFT;
                        bitCnt_q <= '0;
                        txReg_q  <= txLoad_d;
                        miso_q   <= txLoad_d[CMD_BITS-1];
                    end
                end
                SHIFT: begin
                    if (ncsRise) begin
                        state_q <= DECODE;
                        miso_q  <= 1'b0;
                    end else begin
                        if (spckRise) begin
                            shiftReg_q <= shiftIn_d;
                            if (bitCnt_q != CNT_MAX) begin
                                bitCnt_q <= bitCnt_q + CNT_W'(1);
                            end
                        end
                        if (spckFall) begin
                            txReg_q <= txShift_d;
                            miso_q  <= txShift_d[CMD_BITS-1];
                        end
                    end
                end
                DECODE: begin
                    state_q <= IDLE;
                    if (bitCnt_q != CNT_OK) begin
                        frameErr_q <= 1'b1;
                    end else begin
                        case (opcodeField)
                            FPGA_CMD_SET_CONFREG: begin
                                confWord_q  <= shiftReg_q[7:0];
                                cmdValid_q  <= 1'b1;
                                cmdOpcode_q <= opcodeField;
                            end
                            FPGA_CMD_SET_DIVISOR: begin
                                divisor_q   <= shiftReg_q[7:0];
                                cmdValid_q  <= 1'b1;
                                cmdOpcode_q <= opcodeField;
                            end
                            FPGA_CMD_CLR_STATUS: begin
                                frameErr_q  <= 1'b0;
                                cmdValid_q  <= 1'b1;
                                cmdOpcode_q <= opcodeField;
                            end
                            default: begin
                                frameErr_q <= 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign miso       = miso_q;
    assign conf_word  = confWord_q;
    assign divisor    = divisor_q;
    assign cmd_valid  = cmdValid_q;
    assign cmd_opcode = cmdOpcode_q;
    assign frame_err  = frameErr_q;

endmodule
